lsu_stage: RTL and testbench
============================

LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 Parameter XLEN, default 32, data/address width; legal values 32 and 64 only.
REQ-002 Parameter MAX_WAIT, default 15, number of BUSY cycles allowed without valid before a bus error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 load, store  input  1 each  access request from execute stage, level-held while stall=1.
REQ-006 fun3  input  3  instruction[14:12] width/sign code.
REQ-007 alu_out_address  input  XLEN  effective address.
REQ-008 op_b  input  XLEN  store source data.
REQ-009 valid  input  1  memory response strobe.
REQ-010 mem_rdata  input  XLEN  memory read data, sampled when valid=1.
REQ-011 request  output  1  memory request, held until valid.
REQ-012 we_re  output  1  1=write, 0=read; meaningful while request=1.
REQ-013 mem_addr  output  XLEN  latched address.
REQ-014 mask  output  XLEN/8  byte-lane enables.
REQ-015 store_data_out  output  XLEN  lane-aligned store data.
REQ-016 wrap_load_out  output  XLEN  extended load result.
REQ-017 stall  output  1  pipeline hold.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 bus_err  output  1  timeout or illegal-fun3 flag, valid with done.
REQ-020 misalign_err  output  1  misalignment flag, valid with done.

Function
REQ-021 FSM SHALL have states IDLE, BUSY, RESP.
REQ-022 In IDLE with load|store=1 and legal fun3, the block SHALL latch address, fun3, store flag, mask and lane-shifted data and go to BUSY next edge.
REQ-023 load=1 and store=1 together SHALL be a store; load is ignored.
REQ-024 In BUSY: request=1, we_re=latched store, wait counter increments each cycle.
REQ-025 BUSY with valid=1 SHALL capture mem_rdata, clear the counter and go to RESP.
REQ-026 BUSY with counter reaching MAX_WAIT and valid=0 SHALL go to RESP with bus_err=1 and wrap_load_out=0.
REQ-027 RESP SHALL assert done=1 for exactly one cycle, then go to IDLE; request=0 in RESP.
REQ-028 stall SHALL equal (IDLE and (load|store)) or BUSY; stall=0 in RESP.
REQ-029 valid in IDLE or RESP SHALL be ignored.
REQ-030 Minimum latency: request to done is 2 cycles with valid in the first BUSY cycle.
REQ-031 Mask: byte = 1 lane, half = 2 lanes, word = 4 lanes, dword = 8 lanes (XLEN=64 only), shifted by the address low bits.
REQ-032 store_data_out SHALL be op_b's low bytes shifted to the selected lanes; unused lanes are 0.
REQ-033 Loads: 000 LB and 001 LH sign-extend; 100 LBU and 101 LHU zero-extend; 010 LW sign-extends at XLEN=64. At XLEN=64 only: 110 LWU zero-extends and 011 LD is full width.
REQ-034 Illegal fun3 for XLEN or access type SHALL skip BUSY and go IDLE->RESP with bus_err=1 and no request.

Reset
REQ-035 rst=0 at an edge SHALL force IDLE and clear the counter and all outputs (request, we_re, mask, mem_addr, store_data_out, wrap_load_out, stall, done, bus_err, misalign_err) to 0.
REQ-036 Reset mid-BUSY SHALL abandon the access; a valid arriving after reset is ignored.

Configuration
REQ-037 Macro LSU_MISALIGN_TRAP_EN defined: a misaligned access (half addr[0]!=0, word addr[1:0]!=0, dword addr[2:0]!=0) SHALL make no request and go IDLE->RESP with misalign_err=1.
REQ-038 LSU_MISALIGN_TRAP_EN undefined: misalign_err SHALL be tied 0 and the address low bits SHALL be truncated to natural alignment for the lane shift.

Verification
REQ-039 SW, addr 0x100, op_b 0xDEADBEEF, valid after 3 BUSY cycles -> mask 0xF, store_data_out 0xDEADBEEF, request held 3 cycles, done on the 5th cycle.
REQ-040 LB, addr 0x103, mem_rdata 0x80000000 -> wrap_load_out 0xFFFFFF80; the same access as LBU -> 0x00000080.
REQ-041 SH, addr 0x102, op_b 0x1234 -> mask 0xC, store_data_out 0x12340000.
REQ-042 LW with valid never asserted, MAX_WAIT=15 -> bus_err=1 with done after 15 BUSY cycles, wrap_load_out=0.
REQ-043 rst=0 during BUSY, then valid=1 -> no done, all outputs 0, FSM in IDLE.
REQ-044 LW at 0x102 with LSU_MISALIGN_TRAP_EN -> no request, misalign_err=1 with done; without the macro -> request with mem_addr 0x102 and mask 0xF.

Source files
------------

// File: rtl/lsu_stage.sv
// Load/store unit stage: single outstanding memory access, timeout, lane shifting.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_stage #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              store,
  input  logic [2:0]        fun3,
  input  logic [XLEN-1:0]   alu_out_address,
  input  logic [XLEN-1:0]   op_b,
  input  logic              valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              request,
  output logic              we_re,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mask,
  output logic [XLEN-1:0]   store_data_out,
  output logic [XLEN-1:0]   wrap_load_out,
  output logic              stall,
  output logic              done,
  output logic              bus_err,
  output logic              misalign_err
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic          tmo;

  logic          acc;
  logic          legal;
  logic          mis_c;
  logic          ok;
  logic [1:0]    sz;
  logic [OW-1:0] off_raw;
  logic [OW-1:0] amask;
  logic [OW-1:0] off;
  logic [NB-1:0] lane;
  logic [NB-1:0] mask_c;
  logic [XLEN-1:0] bmask;
  logic [XLEN-1:0] sd_c;

  logic          store_q;
  logic [2:0]    fun3_q;
  logic [OW-1:0] off_q;
  logic          err_q;
  logic          mis_q;

  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] lm;
  logic            sgn;
  logic [XLEN-1:0] ext;

  assign acc     = load | store;
  assign sz      = fun3[1:0];
  assign off_raw = alu_out_address[OW-1:0];
  assign amask   = {OW{1'b1}} << sz;
  assign off     = off_raw & amask;
  assign lane    = ~({NB{1'b1}} << (4'd1 << sz));
  assign mask_c  = lane << off;
  assign bmask   = ~({XLEN{1'b1}} << (7'd8 << sz));
  assign sd_c    = (op_b & bmask) << {off, 3'b000};

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_c        = (off_raw & ~amask) != '0;
  assign misalign_err = mis_q;
`else
  assign mis_c        = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign ok = legal & ~mis_c;

  // Legal width codes depend on access type and XLEN; store wins over load.
  always_comb begin
    legal = 1'b0;
    if (store) begin
      case (fun3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        3'b011:                 legal = (XLEN == 64);
        default:                legal = 1'b0;
      endcase
    end else if (load) begin
      case (fun3)
        3'b000, 3'b001, 3'b010,
        3'b100, 3'b101:         legal = 1'b1;
        3'b011, 3'b110:         legal = (XLEN == 64);
        default:                legal = 1'b0;
      endcase
    end
  end

  // Load result: shift selected lanes down, then zero- or sign-extend.
  always_comb begin
    sh  = mem_rdata >> {off_q, 3'b000};
    lm  = ~({XLEN{1'b1}} << (7'd8 << fun3_q[1:0]));
    sgn = 1'b0;
    unique case (fun3_q[1:0])
      2'd0:    sgn = sh[7];
      2'd1:    sgn = sh[15];
      2'd2:    sgn = sh[31];
      default: sgn = sh[XLEN-1];
    endcase
    ext = sh & lm;
    if (!fun3_q[2] && sgn) ext = ext | ~lm;
  end

  assign tmo = (cnt == CW'(MAX_WAIT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state: errors detected at issue bypass the bus entirely.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (acc) state_nx = ok ? BUSY : RESP;
      BUSY: if (valid || tmo) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Access latch, wait counter and response capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt            <= '0;
      store_q        <= 1'b0;
      fun3_q         <= '0;
      off_q          <= '0;
      mem_addr       <= '0;
      mask           <= '0;
      store_data_out <= '0;
      wrap_load_out  <= '0;
      err_q          <= 1'b0;
      mis_q          <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            cnt            <= '0;
            store_q        <= store;
            fun3_q         <= fun3;
            off_q          <= off;
            mem_addr       <= alu_out_address;
            mask           <= ok ? mask_c : '0;
            store_data_out <= (ok && store) ? sd_c : '0;
            wrap_load_out  <= '0;
            err_q          <= ~legal;
            mis_q          <= legal & mis_c;
          end
        end
        BUSY: begin
          if (valid) begin
            cnt           <= '0;
            wrap_load_out <= store_q ? '0 : ext;
          end else if (tmo) begin
            cnt           <= '0;
            err_q         <= 1'b1;
            wrap_load_out <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          err_q <= 1'b0;
          mis_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign request = (state == BUSY);
  assign we_re   = request & store_q;
  assign stall   = ((state == IDLE) & acc) | (state == BUSY);
  assign done    = (state == RESP);
  assign bus_err = err_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Scoreboard bench for lsu_stage at XLEN=32, MAX_WAIT=15.
// Expectations follow LSU_MISALIGN_TRAP_EN when the bench is built with it.
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic        store = 1'b0;
  logic [2:0]  fun3 = '0;
  logic [31:0] alu_out_address = '0;
  logic [31:0] op_b = '0;
  logic        valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        request;
  logic        we_re;
  logic [31:0] mem_addr;
  logic [3:0]  mask;
  logic [31:0] store_data_out;
  logic [31:0] wrap_load_out;
  logic        stall;
  logic        done;
  logic        bus_err;
  logic        misalign_err;

  typedef struct {
    logic        err;
    logic        mis;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wrap;
    logic [31:0] sd;
    logic [3:0]  mask;
    int          reqs;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   reqs = 0;
  logic we_seen = 1'b0;
  logic prev_done = 1'b0;

  lsu_stage #(.XLEN(32), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .load(load), .store(store), .fun3(fun3),
    .alu_out_address(alu_out_address), .op_b(op_b), .valid(valid),
    .mem_rdata(mem_rdata), .request(request), .we_re(we_re),
    .mem_addr(mem_addr), .mask(mask), .store_data_out(store_data_out),
    .wrap_load_out(wrap_load_out), .stall(stall), .done(done),
    .bus_err(bus_err), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      reqs = 0;
      we_seen = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (request) begin
        reqs++;
        we_seen = we_re;
      end
      if (done) begin
        cmp("done_one_cycle", {31'b0, prev_done}, 32'd0);
        if (sbq.size() == 0) begin
          cmp("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          cmp("bus_err", {31'b0, bus_err}, {31'b0, e.err});
          cmp("misalign_err", {31'b0, misalign_err}, {31'b0, e.mis});
          cmp("we_re", {31'b0, we_seen}, {31'b0, e.we});
          cmp("mem_addr", mem_addr, e.addr);
          cmp("mask", {28'b0, mask}, {28'b0, e.mask});
          cmp("store_data_out", store_data_out, e.sd);
          cmp("wrap_load_out", wrap_load_out, e.wrap);
          cmp("request_cycles", reqs, e.reqs);
          cmp("stall_in_resp", {31'b0, stall}, 32'd0);
        end
        reqs = 0;
        we_seen = 1'b0;
      end
      prev_done = done;
    end
  end

  task automatic access(
    input logic ld, input logic st, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] ob,
    input int vd, input logic [31:0] rd,
    input logic e_err, input logic e_mis, input logic e_we,
    input logic [31:0] e_wrap, input logic [31:0] e_sd,
    input logic [3:0] e_mask, input int e_reqs);
    exp_t e;
    bit   seen;
    e.err = e_err; e.mis = e_mis; e.we = e_we; e.addr = a;
    e.wrap = e_wrap; e.sd = e_sd; e.mask = e_mask; e.reqs = e_reqs;
    sbq.push_back(e);
    @(posedge clk); #1;
    load = ld; store = st; fun3 = f3;
    alu_out_address = a; op_b = ob;
    @(posedge clk); #1;
    load = 1'b0; store = 1'b0;
    if (vd > 0) begin
      repeat (vd - 1) begin
        @(posedge clk); #1;
      end
      valid = 1'b1; mem_rdata = rd;
      @(posedge clk); #1;
      valid = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) cmp("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_request"}, {31'b0, request}, 32'd0);
    cmp({tag, "_we_re"}, {31'b0, we_re}, 32'd0);
    cmp({tag, "_mem_addr"}, mem_addr, 32'd0);
    cmp({tag, "_mask"}, {28'b0, mask}, 32'd0);
    cmp({tag, "_store_data"}, store_data_out, 32'd0);
    cmp({tag, "_wrap"}, wrap_load_out, 32'd0);
    cmp({tag, "_stall"}, {31'b0, stall}, 32'd0);
    cmp({tag, "_done"}, {31'b0, done}, 32'd0);
    cmp({tag, "_bus_err"}, {31'b0, bus_err}, 32'd0);
    cmp({tag, "_misalign"}, {31'b0, misalign_err}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // SW 0x100, valid in third BUSY cycle
    access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 3, 32'h0,
           0, 0, 1, 32'h0, 32'hDEADBEEF, 4'hF, 3);
    // LB / LBU at 0x103
    access(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80000000,
           0, 0, 0, 32'hFFFFFF80, 32'h0, 4'h8, 1);
    access(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80000000,
           0, 0, 0, 32'h00000080, 32'h0, 4'h8, 1);
    // SH 0x102, upper op_b bytes must not leak
    access(0, 1, 3'b001, 32'h102, 32'hABCD1234, 1, 32'h0,
           0, 0, 1, 32'h0, 32'h12340000, 4'hC, 1);
    // LH / LHU at 0x102
    access(1, 0, 3'b001, 32'h102, 32'h0, 2, 32'h80010000,
           0, 0, 0, 32'hFFFF8001, 32'h0, 4'hC, 2);
    access(1, 0, 3'b101, 32'h102, 32'h0, 1, 32'h80010000,
           0, 0, 0, 32'h00008001, 32'h0, 4'hC, 1);
    // SB 0x101
    access(0, 1, 3'b000, 32'h101, 32'hFFFFFFA5, 1, 32'h0,
           0, 0, 1, 32'h0, 32'h0000A500, 4'h2, 1);
    // LW 0x104
    access(1, 0, 3'b010, 32'h104, 32'h0, 1, 32'h12345678,
           0, 0, 0, 32'h12345678, 32'h0, 4'hF, 1);
    // LW timeout
    access(1, 0, 3'b010, 32'h200, 32'h0, 0, 32'h0,
           1, 0, 0, 32'h0, 32'h0, 4'hF, 15);
    // illegal codes: load 111, store 100, LD at XLEN=32
    access(1, 0, 3'b111, 32'h10, 32'h0, 0, 32'h0,
           1, 0, 0, 32'h0, 32'h0, 4'h0, 0);
    access(0, 1, 3'b100, 32'h14, 32'h55, 0, 32'h0,
           1, 0, 0, 32'h0, 32'h0, 4'h0, 0);
    access(1, 0, 3'b011, 32'h18, 32'h0, 0, 32'h0,
           1, 0, 0, 32'h0, 32'h0, 4'h0, 0);
    // load+store together is a store
    access(1, 1, 3'b010, 32'h108, 32'hCAFEF00D, 1, 32'h77777777,
           0, 0, 1, 32'h0, 32'hCAFEF00D, 4'hF, 1);
`ifdef LSU_MISALIGN_TRAP_EN
    access(1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h0,
           0, 1, 0, 32'h0, 32'h0, 4'h0, 0);
    access(0, 1, 3'b001, 32'h103, 32'h5678, 0, 32'h0,
           0, 1, 0, 32'h0, 32'h0, 4'h0, 0);
`else
    access(1, 0, 3'b010, 32'h102, 32'h0, 1, 32'h11223344,
           0, 0, 0, 32'h11223344, 32'h0, 4'hF, 1);
    access(0, 1, 3'b001, 32'h103, 32'h5678, 1, 32'h0,
           0, 0, 1, 32'h0, 32'h56780000, 4'hC, 1);
`endif

    // reset in the middle of BUSY, then a stray valid
    @(posedge clk); #1;
    load = 1'b1; fun3 = 3'b010; alu_out_address = 32'h300;
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    valid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check_zero("midbusy_reset");
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      cmp("post_reset_done", {31'b0, done}, 32'd0);
      cmp("post_reset_request", {31'b0, request}, 32'd0);
    end

    repeat (2) @(posedge clk);
    cmp("scoreboard_empty", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
